// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Request/response ports of both clients plus the memory pins
//               of the two-client memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              resp0_valid;
    logic [DATA_W-1:0] resp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_read_write;
    logic              mem_chip_en;
    logic              busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, resp0_valid, resp0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, resp1_valid, resp1_rdata,
        output mem_address, mem_data_in, mem_read_write, mem_chip_en, busy,
        input  mem_data_out
    );

    // Client / memory side
    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, resp0_valid, resp0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, resp1_valid, resp1_rdata,
        input  mem_address, mem_data_in, mem_read_write, mem_chip_en, busy,
        output mem_data_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one asynchronous 256x8 memory
//               between two clients with a setup/strobe/response sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_STROBE = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_last_grant;
    logic              r_owner;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_grant_valid;
    logic              w_grant;
    logic              w_accept;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // A tie goes to the requester that did not win last time.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant       = ~r_last_grant;
        end else if (bus.req0_valid) begin
            w_grant_valid = 1'b1;
            w_grant       = 1'b0;
        end else if (bus.req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant       = 1'b1;
        end
        w_accept    = (r_state == c_ST_IDLE) && !rst && w_grant_valid;
        w_sel_write = w_grant ? bus.req1_write : bus.req0_write;
        w_sel_addr  = w_grant ? bus.req1_addr  : bus.req0_addr;
        w_sel_wdata = w_grant ? bus.req1_wdata : bus.req0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_state_next = c_ST_SETUP;
            c_ST_SETUP:  w_state_next = c_ST_STROBE;
            c_ST_STROBE: w_state_next = c_ST_RESP;
            c_ST_RESP:   w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // chip_en and busy decode straight from state so reset drops them at once.
    always_comb begin
        bus.req0_ready     = 1'b0;
        bus.req1_ready     = 1'b0;
        bus.mem_chip_en    = 1'b0;
        bus.busy           = 1'b1;
        bus.resp0_valid    = 1'b0;
        bus.resp1_valid    = 1'b0;
        bus.mem_read_write = r_write && (r_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE: begin
                bus.busy       = 1'b0;
                bus.req0_ready = w_accept && !w_grant;
                bus.req1_ready = w_accept &&  w_grant;
            end
            c_ST_STROBE: bus.mem_chip_en = 1'b1;
            c_ST_RESP: begin
                bus.resp0_valid = !r_owner;
                bus.resp1_valid =  r_owner;
            end
            default: ;
        endcase
    end

    // Address/data load on the accept edge, so they settle during SETUP and
    // stay put until the next accept, well clear of the chip_en pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_owner      <= w_grant;
                r_write      <= w_sel_write;
                r_addr       <= w_sel_addr;
                if (w_sel_write) begin
                    r_wdata <= w_sel_wdata;
                end
            end
            if (r_state == c_ST_STROBE && !r_write) begin
                if (r_owner) begin
                    r_rdata1 <= bus.mem_data_out;
                end else begin
                    r_rdata0 <= bus.mem_data_out;
                end
            end
        end
    end

    assign bus.mem_address = r_addr;
    assign bus.mem_data_in = r_wdata;
    assign bus.resp0_rdata = r_rdata0;
    assign bus.resp1_rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed bench for mem_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behaviour: combinational read, write while chip_en is high.
    logic [7:0] tb_mem [256];
    always @(posedge clk)
        if (bus.mem_chip_en && bus.mem_read_write)
            tb_mem[bus.mem_address] <= bus.mem_data_in;
    assign bus.mem_data_out = tb_mem[bus.mem_address];

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transaction model: phase counts cycles since acceptance (0 = idle).
    int         m_phase;
    logic       m_last, m_owner, m_write;
    logic [7:0] m_addr, m_din, m_rdata0, m_rdata1;
    logic [7:0] m_mem [256];

    always @(negedge clk) begin : model
        logic gv, g;
        if (rst) begin
            check_b("rst_busy", bus.busy, 1'b0);
            check_b("rst_ready0", bus.req0_ready, 1'b0);
            check_b("rst_ready1", bus.req1_ready, 1'b0);
            check_b("rst_chip_en", bus.mem_chip_en, 1'b0);
            check_b("rst_read_write", bus.mem_read_write, 1'b0);
            check_b("rst_resp0", bus.resp0_valid, 1'b0);
            check_b("rst_resp1", bus.resp1_valid, 1'b0);
            check_v("rst_address", 32'(bus.mem_address), 32'h0);
            check_v("rst_data_in", 32'(bus.mem_data_in), 32'h0);
            check_v("rst_rdata0", 32'(bus.resp0_rdata), 32'h0);
            check_v("rst_rdata1", 32'(bus.resp1_rdata), 32'h0);
            m_phase = 0; m_last = 1'b1; m_owner = 1'b0; m_write = 1'b0;
            m_addr = 8'h00; m_din = 8'h00; m_rdata0 = 8'h00; m_rdata1 = 8'h00;
        end else begin
            gv = 1'b0;
            g  = 1'b0;
            if (m_phase == 0) begin
                if (bus.req0_valid && bus.req1_valid) begin gv = 1'b1; g = ~m_last; end
                else if (bus.req0_valid) begin gv = 1'b1; g = 1'b0; end
                else if (bus.req1_valid) begin gv = 1'b1; g = 1'b1; end
            end
            check_b("ready_exclusive", bus.req0_ready && bus.req1_ready, 1'b0);
            check_b("ready0", bus.req0_ready, gv && !g);
            check_b("ready1", bus.req1_ready, gv && g);
            check_b("busy", bus.busy, m_phase != 0);
            check_b("chip_en", bus.mem_chip_en, m_phase == 2);
            check_b("read_write", bus.mem_read_write, (m_phase != 0) && m_write);
            check_v("mem_address", 32'(bus.mem_address), 32'(m_addr));
            check_v("mem_data_in", 32'(bus.mem_data_in), 32'(m_din));
            check_b("resp0_valid", bus.resp0_valid, m_phase == 3 && !m_owner);
            check_b("resp1_valid", bus.resp1_valid, m_phase == 3 && m_owner);
            check_v("resp0_rdata", 32'(bus.resp0_rdata), 32'(m_rdata0));
            check_v("resp1_rdata", 32'(bus.resp1_rdata), 32'(m_rdata1));
            case (m_phase)
                0: if (gv) begin
                    m_phase = 1;
                    m_owner = g;
                    m_last  = g;
                    m_write = g ? bus.req1_write : bus.req0_write;
                    m_addr  = g ? bus.req1_addr  : bus.req0_addr;
                    if (m_write) begin
                        m_din = g ? bus.req1_wdata : bus.req0_wdata;
                        m_mem[m_addr] = m_din;
                    end
                end
                1: m_phase = 2;
                2: begin
                    if (!m_write) begin
                        if (m_owner) m_rdata1 = m_mem[m_addr];
                        else         m_rdata0 = m_mem[m_addr];
                    end
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Memory pins must read the same when chip_en falls as when it rose.
    logic [7:0] ce_addr, ce_din;
    logic       ce_rw;
    always @(posedge bus.mem_chip_en) begin
        ce_addr = bus.mem_address;
        ce_din  = bus.mem_data_in;
        ce_rw   = bus.mem_read_write;
    end
    always @(negedge bus.mem_chip_en) begin
        if (!rst) begin
            check_v("ce_addr_stable", 32'(bus.mem_address), 32'(ce_addr));
            check_v("ce_data_stable", 32'(bus.mem_data_in), 32'(ce_din));
            check_b("ce_rw_stable", bus.mem_read_write, ce_rw);
        end
    end

    task automatic txn(input logic who, input logic wr, input logic [7:0] addr,
                       input logic [7:0] data, output logic [7:0] rdata);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        if (!who) begin
            bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = addr; bus.req0_wdata = data;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = addr; bus.req1_wdata = data;
        end
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = who ? bus.req1_ready : bus.req0_ready;
        end
        check_b("txn_handshake", got, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check_b("txn_setup_ce_low", bus.mem_chip_en, 1'b0);
        @(negedge clk);
        check_b("txn_strobe_ce_high", bus.mem_chip_en, 1'b1);
        check_v("txn_strobe_addr", 32'(bus.mem_address), 32'(addr));
        check_b("txn_strobe_rw", bus.mem_read_write, wr);
        if (wr) check_v("txn_strobe_data", 32'(bus.mem_data_in), 32'(data));
        @(negedge clk);
        check_b("txn_resp_owner", who ? bus.resp1_valid : bus.resp0_valid, 1'b1);
        check_b("txn_resp_other", who ? bus.resp0_valid : bus.resp1_valid, 1'b0);
        check_b("txn_resp_ce_low", bus.mem_chip_en, 1'b0);
        rdata = who ? bus.resp1_rdata : bus.resp0_rdata;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] rd;
        logic       found, who;
        int         prev;
        n_checks = 0; n_pass = 0; cyc = 0;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 8'h00;
            m_mem[i]  = 8'h00;
        end
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = 8'h00; bus.req0_wdata = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = 8'h00; bus.req1_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single write then read-back by the other client
        txn(1'b0, 1'b1, 8'h10, 8'hA5, rd);
        txn(1'b1, 1'b0, 8'h10, 8'h00, rd);
        check_v("t2_read_after_write", 32'(rd), 32'hA5);

        // Continuous contention straight after reset alternates 0,1,0,1...
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 8'h30; bus.req0_wdata = 8'h11;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 8'h30;
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            found = 1'b0;
            who   = 1'b0;
            for (int n = 0; n < 20 && !found; n++) begin
                @(negedge clk);
                if (bus.req0_ready)      begin found = 1'b1; who = 1'b0; end
                else if (bus.req1_ready) begin found = 1'b1; who = 1'b1; end
            end
            check_b("t3_handshake", found, 1'b1);
            check_b("t3_grant_order", who, k[0]);
            if (k > 0) check_v("t3_grant_spacing", 32'(cyc - prev), 32'd4);
            prev = cyc;
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (5) @(negedge clk);

        // Full address sweep including 0x00 and 0xFF
        for (int a = 0; a < 256; a++) txn(1'b0, 1'b1, 8'(a), 8'(a), rd);
        for (int a = 0; a < 256; a++) begin
            txn(1'b1, 1'b0, 8'(a), 8'h00, rd);
            check_v("t4_sweep_read", 32'(rd), 32'(a));
        end

        // Reset during the strobe of a write
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 8'h20; bus.req0_wdata = 8'h5A;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            found = bus.req0_ready;
        end
        check_b("t5_handshake", found, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_b("t5_strobe_ce", bus.mem_chip_en, 1'b1);
        check_b("t5_strobe_busy", bus.busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_b("t5_async_ce_low", bus.mem_chip_en, 1'b0);
        check_b("t5_async_busy_low", bus.busy, 1'b0);
        check_v("t5_async_address", 32'(bus.mem_address), 32'h0);
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 8'h05;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 8'h06;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        found = 1'b0;
        who   = 1'b1;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            check_b("t5_no_resp0", bus.resp0_valid, 1'b0);
            if (bus.req0_ready)      begin found = 1'b1; who = 1'b0; end
            else if (bus.req1_ready) begin found = 1'b1; who = 1'b1; end
        end
        check_b("t5_first_tie_handshake", found, 1'b1);
        check_b("t5_first_tie_winner", who, 1'b0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_b("t5_resp0_after_reset", bus.resp0_valid, 1'b1);
        check_v("t5_rdata0_after_reset", 32'(bus.resp0_rdata), 32'h05);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
